regfile_writeback: RTL and testbench

//  Producer-side front end of the regfile write ports. Takes results from two independent

---
 rtl/regfile_writeback.sv | 124 ++++++++++++
 tb/tb_regfile_writeback.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Regfile write-port front end: two producer streams, each buffered in its own FIFO,
// drained onto write ports C and D with same-address ordering and a pending-write scoreboard.
module regfile_writeback #(
    parameter int unsigned REG_CNT           = 4,
    parameter int unsigned SUPERSCALAR_WIDTH = 4,
    parameter int unsigned REG_WIDTH         = 288,
    parameter int unsigned FIFO_DEPTH        = 4,
    localparam int unsigned NUM_REGS         = REG_CNT * SUPERSCALAR_WIDTH,
    localparam int unsigned ADDR_W           = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic                 s0_valid,
    output logic                 s0_ready,
    input  logic [ADDR_W-1:0]    s0_addr,
    input  logic [REG_WIDTH-1:0] s0_data,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic [ADDR_W-1:0]    s1_addr,
    input  logic [REG_WIDTH-1:0] s1_data,
    output logic                 port_c_we,
    output logic [ADDR_W-1:0]    port_c_write_addr,
    output logic [REG_WIDTH-1:0] port_c_in,
    output logic                 port_d_we,
    output logic [ADDR_W-1:0]    port_d_write_addr,
    output logic [REG_WIDTH-1:0] port_d_in,
    output logic [NUM_REGS-1:0]  pending_mask
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [REG_WIDTH-1:0] data;
    } wb_entry_t;

    wb_entry_t        r_mem   [2][FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr  [2];
    logic [PTR_W-1:0] r_rptr  [2];
    logic [CNT_W-1:0] r_count [2];

    wb_entry_t     w_in   [2];
    wb_entry_t     w_head [2];
    logic [1:0]    w_valid;
    logic [1:0]    w_empty;
    logic [1:0]    w_full;
    logic [1:0]    w_push;
    logic [1:0]    w_we;
    logic          w_collide;
    logic [NUM_REGS-1:0] w_pending;

    assign w_valid  = {s1_valid, s0_valid};
    assign w_in[0]  = '{addr: s0_addr, data: s0_data};
    assign w_in[1]  = '{addr: s1_addr, data: s1_data};

    for (genvar g = 0; g < 2; g++) begin : g_stream
        assign w_empty[g] = (r_count[g] == '0);
        assign w_full[g]  = (r_count[g] == CNT_W'(FIFO_DEPTH));
        assign w_push[g]  = w_valid[g] && !w_full[g];
        assign w_head[g]  = r_mem[g][r_rptr[g]];

        a_push_not_full: assert property (@(posedge clk) disable iff (!reset)
            w_push[g] |-> !w_full[g]);
    end

    // Same-address heads: stream 0 writes first, stream 1 is held a cycle so it lands last.
    assign w_collide = !w_empty[0] && !w_empty[1] && (w_head[0].addr == w_head[1].addr);
    assign w_we[0]   = !freeze && !w_empty[0];
    assign w_we[1]   = !freeze && !w_empty[1] && !w_collide;

    // FIFO storage, pointers and occupancy; a pop happens exactly when the port writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    r_mem[s][i] <= '0;
                end
                r_wptr[s]  <= '0;
                r_rptr[s]  <= '0;
                r_count[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_mem[s][r_wptr[s]] <= w_in[s];
                    r_wptr[s]           <= r_wptr[s] + PTR_W'(1);
                end
                if (w_we[s]) begin
                    r_rptr[s] <= r_rptr[s] + PTR_W'(1);
                end
                case ({w_push[s], w_we[s]})
                    2'b10:   r_count[s] <= r_count[s] + CNT_W'(1);
                    2'b01:   r_count[s] <= r_count[s] - CNT_W'(1);
                    default: r_count[s] <= r_count[s];
                endcase
            end
        end
    end

    // Entry i is live when its distance from the read pointer is below the count.
    always_comb begin
        w_pending = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (CNT_W'(PTR_W'(PTR_W'(i) - r_rptr[s])) < r_count[s]) begin
                    w_pending[r_mem[s][i].addr] = 1'b1;
                end
            end
        end
    end

    assign s0_ready          = !w_full[0];
    assign s1_ready          = !w_full[1];
    assign port_c_we         = w_we[0];
    assign port_c_write_addr = w_we[0] ? w_head[0].addr : '0;
    assign port_c_in         = w_we[0] ? w_head[0].data : '0;
    assign port_d_we         = w_we[1];
    assign port_d_write_addr = w_we[1] ? w_head[1].addr : '0;
    assign port_d_in         = w_we[1] ? w_head[1].data : '0;
    assign pending_mask      = w_pending;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and model-checked stimulus for regfile_writeback; drives after each posedge, samples 2ns later.
module tb_regfile_writeback;

    localparam int unsigned RW = 288;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          freeze;
    logic          s0_valid, s0_ready, s1_valid, s1_ready;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [RW-1:0] s0_data, s1_data;
    logic          port_c_we, port_d_we;
    logic [AW-1:0] port_c_write_addr, port_d_write_addr;
    logic [RW-1:0] port_c_in, port_d_in;
    logic [NR-1:0] pending_mask;

    int n_tests = 0;
    int n_fail  = 0;

    logic [RW-1:0] rf  [NR];
    logic [RW-1:0] mrf [NR];
    logic [NR-1:0] wmask;
    ent_t          q0[$], q1[$];
    logic          v0, v1, fr, e_c, e_d, coll, p0, p1;
    logic [NR-1:0] e_mask;

    regfile_writeback dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .port_c_we(port_c_we), .port_c_write_addr(port_c_write_addr), .port_c_in(port_c_in),
        .port_d_we(port_d_we), .port_d_write_addr(port_d_write_addr), .port_d_in(port_d_in),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    // Regfile sink: C commits before D on the same edge.
    always @(posedge clk) begin
        if (port_c_we) rf[port_c_write_addr] <= port_c_in;
        if (port_d_we) rf[port_d_write_addr] <= port_d_in;
    end

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_c_we"}, RW'(port_c_we), RW'(1'b0));
        check({tag, "_d_we"}, RW'(port_d_we), RW'(1'b0));
        check({tag, "_c_addr"}, RW'(port_c_write_addr), RW'(0));
        check({tag, "_c_data"}, port_c_in, RW'(0));
    endtask

    initial begin
        reset = 1'b0; freeze = 1'b0;
        s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
        s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
        for (int i = 0; i < NR; i++) begin
            rf[i] = '0; mrf[i] = '0;
        end
        wmask = '0;
        #3;
        check_idle("rst");
        check("rst_pend", RW'(pending_mask), RW'(0));
        check("rst_rdy0", RW'(s0_ready), RW'(1'b1));
        check("rst_rdy1", RW'(s1_ready), RW'(1'b1));
        tick();
        reset = 1'b1;
        tick();

        // 1: buffer 3 entries under freeze, then reset mid-stream
        freeze = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            s0_valid = 1'b1; s0_addr = AW'(k); s0_data = RW'(k + 40);
            tick();
        end
        s0_valid = 1'b0;
        #1;
        check("t1_pend3", RW'(pending_mask), RW'(16'h000E));
        check("t1_frz_we", RW'(port_c_we), RW'(1'b0));
        reset = 1'b0;
        #1;
        check_idle("t1_inrst");
        check("t1_inrst_pend", RW'(pending_mask), RW'(0));
        tick();
        reset = 1'b1; freeze = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_idle("t1_after");
            check("t1_after_pend", RW'(pending_mask), RW'(0));
            check("t1_after_rdy", RW'(s0_ready), RW'(1'b1));
            tick();
        end

        // 2: single push, one-cycle latency
        s0_valid = 1'b1; s0_addr = 4'd15; s0_data = RW'(2);
        tick();
        s0_valid = 1'b0;
        #1;
        check("t2_we", RW'(port_c_we), RW'(1'b1));
        check("t2_addr", RW'(port_c_write_addr), RW'(15));
        check("t2_data", port_c_in, RW'(2));
        check("t2_pend", RW'(pending_mask), RW'(16'h8000));
        tick();
        check("t2_we_after", RW'(port_c_we), RW'(1'b0));
        check("t2_pend_after", RW'(pending_mask), RW'(0));
        check("t2_rf15", rf[15], RW'(2));

        // 3: same-address collision; stream 1 must land last
        s0_valid = 1'b1; s0_addr = 4'd5; s0_data = RW'(7);
        s1_valid = 1'b1; s1_addr = 4'd5; s1_data = RW'(9);
        tick();
        s0_valid = 1'b0; s1_valid = 1'b0;
        #1;
        check("t3_c1_we", RW'(port_c_we), RW'(1'b1));
        check("t3_c1_data", port_c_in, RW'(7));
        check("t3_d1_we", RW'(port_d_we), RW'(1'b0));
        check("t3_d1_addr", RW'(port_d_write_addr), RW'(0));
        check("t3_pend", RW'(pending_mask), RW'(16'h0020));
        tick();
        check("t3_c2_we", RW'(port_c_we), RW'(1'b0));
        check("t3_d2_we", RW'(port_d_we), RW'(1'b1));
        check("t3_d2_addr", RW'(port_d_write_addr), RW'(5));
        check("t3_d2_data", port_d_in, RW'(9));
        tick();
        check("t3_d3_we", RW'(port_d_we), RW'(1'b0));
        check("t3_rf5", rf[5], RW'(9));

        // 4: fill stream 1 under freeze, then drain in order
        freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s1_valid = 1'b1; s1_addr = AW'(8 + k); s1_data = RW'(100 + k);
            #1;
            check("t4_rdy", RW'(s1_ready), RW'(1'b1));
            check("t4_frz_we", RW'(port_d_we), RW'(1'b0));
            tick();
        end
        s1_addr = 4'd13; s1_data = RW'(999);
        #1;
        check("t4_full_rdy", RW'(s1_ready), RW'(1'b0));
        check("t4_full_pend", RW'(pending_mask), RW'(16'h0F00));
        tick();
        check("t4_full_rdy2", RW'(s1_ready), RW'(1'b0));
        s1_valid = 1'b0; freeze = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_d_we", RW'(port_d_we), RW'(1'b1));
            check("t4_d_addr", RW'(port_d_write_addr), RW'(8 + k));
            check("t4_d_data", port_d_in, RW'(100 + k));
            tick();
        end
        check("t4_done_we", RW'(port_d_we), RW'(1'b0));
        check("t4_done_rdy", RW'(s1_ready), RW'(1'b1));
        check("t4_rf13", rf[13], RW'(0));

        // 5: ten back-to-back pushes on stream 0, pointers wrap
        for (int i = 0; i < 10; i++) begin
            s0_valid = 1'b1; s0_addr = AW'(i); s0_data = RW'(3 * i + 1);
            #1;
            check("t5_rdy", RW'(s0_ready), RW'(1'b1));
            if (i > 0) begin
                check("t5_addr", RW'(port_c_write_addr), RW'(i - 1));
                check("t5_data", port_c_in, RW'(3 * (i - 1) + 1));
            end else begin
                check("t5_first_we", RW'(port_c_we), RW'(1'b0));
            end
            tick();
        end
        s0_valid = 1'b0;
        #1;
        check("t5_last_addr", RW'(port_c_write_addr), RW'(9));
        check("t5_last_data", port_c_in, RW'(28));
        tick();
        check("t5_end_we", RW'(port_c_we), RW'(1'b0));

        // 6: random traffic against a queue-based model, with a drain tail
        for (int cyc = 0; cyc < 560; cyc++) begin
            v0 = (cyc < 500) && ($urandom_range(0, 1) == 1);
            v1 = (cyc < 500) && ($urandom_range(0, 1) == 1);
            fr = (cyc < 500) && ($urandom_range(0, 3) == 0);
            freeze = fr;
            s0_valid = v0; s0_addr = AW'($urandom_range(0, 15)); s0_data = {9{$urandom}};
            s1_valid = v1; s1_addr = AW'($urandom_range(0, 15)); s1_data = {9{$urandom}};
            #1;
            coll = (q0.size() > 0) && (q1.size() > 0) && (q0[0].addr == q1[0].addr);
            e_c  = !fr && (q0.size() > 0);
            e_d  = !fr && (q1.size() > 0) && !coll;
            e_mask = '0;
            foreach (q0[k]) e_mask[q0[k].addr] = 1'b1;
            foreach (q1[k]) e_mask[q1[k].addr] = 1'b1;
            check("r_c_we", RW'(port_c_we), RW'(e_c));
            check("r_d_we", RW'(port_d_we), RW'(e_d));
            check("r_c_addr", RW'(port_c_write_addr), e_c ? RW'(q0[0].addr) : RW'(0));
            check("r_c_data", port_c_in, e_c ? q0[0].data : RW'(0));
            check("r_d_addr", RW'(port_d_write_addr), e_d ? RW'(q1[0].addr) : RW'(0));
            check("r_d_data", port_d_in, e_d ? q1[0].data : RW'(0));
            check("r_rdy0", RW'(s0_ready), RW'(q0.size() != 4));
            check("r_rdy1", RW'(s1_ready), RW'(q1.size() != 4));
            check("r_pend", RW'(pending_mask), RW'(e_mask));
            p0 = v0 && (q0.size() < 4);
            p1 = v1 && (q1.size() < 4);
            if (e_c) begin
                mrf[q0[0].addr] = q0[0].data; wmask[q0[0].addr] = 1'b1;
                void'(q0.pop_front());
            end
            if (e_d) begin
                mrf[q1[0].addr] = q1[0].data; wmask[q1[0].addr] = 1'b1;
                void'(q1.pop_front());
            end
            if (p0) q0.push_back('{addr: s0_addr, data: s0_data});
            if (p1) q1.push_back('{addr: s1_addr, data: s1_data});
            tick();
        end
        check("r_drained0", RW'(q0.size()), RW'(0));
        check("r_drained1", RW'(q1.size()), RW'(0));
        for (int i = 0; i < NR; i++) begin
            if (wmask[i]) check("r_rf", rf[i], mrf[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
